// File: rtl/gate_eval_sequencer.sv
// Shared microfluidic gate sequencer: arbitrates two requesters, drives a/b, samples y.
// Optional flush phase is enabled by defining GATE_SEQ_FLUSH_EN.
module gate_eval_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 200,
  parameter int unsigned FLUSH_CYCLES  = 100,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_ab,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_ab,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [1:0] rsp_ab,
  output logic       rsp_y,
  output logic       sol_a,
  output logic       sol_b,
  output logic       sol_flush,
  input  logic       sens_y,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    FLUSH,
    RESP
  } state_t;

  localparam int unsigned S_EFF =
    (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] S_LOAD =
    CNT_W'(S_EFF - 1);

`ifdef GATE_SEQ_FLUSH_EN
  localparam int unsigned F_EFF =
    (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;
  localparam logic [CNT_W-1:0] F_LOAD =
    CNT_W'(F_EFF - 1);
  logic sol_flush_q;
  assign sol_flush = sol_flush_q;
`else
  logic unused_flush;
  assign unused_flush = ^FLUSH_CYCLES;
  assign sol_flush = 1'b0;
`endif

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             y_meta;
  logic             y_sync;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [1:0]       acc_ab;

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid): begin
        gnt0 = last;
        gnt1 = ~last;
      end
      (req0_valid & ~req1_valid): gnt0 = 1'b1;
      (~req0_valid & req1_valid): gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign acc_ab     = req1_ready ? req1_ab : req0_ab;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      y_meta <= sens_y;
      y_sync <= y_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_ab    <= 2'b00;
      rsp_y     <= 1'b0;
      sol_a     <= 1'b0;
      sol_b     <= 1'b0;
`ifdef GATE_SEQ_FLUSH_EN
      sol_flush_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= req1_ready;
            rsp_ab <= acc_ab;
            last   <= req1_ready;
            cnt    <= S_LOAD;
            sol_a  <= acc_ab[1];
            sol_b  <= acc_ab[0];
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_y <= y_sync;
            sol_a <= 1'b0;
            sol_b <= 1'b0;
`ifdef GATE_SEQ_FLUSH_EN
            sol_flush_q <= 1'b1;
            cnt         <= F_LOAD;
            state       <= FLUSH;
`else
            rsp_valid <= 1'b1;
            state     <= RESP;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef GATE_SEQ_FLUSH_EN
        FLUSH: begin
          if (cnt == '0) begin
            sol_flush_q <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
